snake_frame_renderer: RTL

- Reads the snake game state (positions array, length, food position, game_over) and builds a 16x16 cell map for the display path.
- The game logic writes this state; this block is its reader.
- The map is built in a double-buffered fashion: a back buffer is written by a small walk FSM, then swapped into a front buffer.
- The display driver samples the front buffer through a combinational read port, so it never sees a half-built frame.

---
 rtl/snake_pkg.sv | 17 +
 rtl/snake_cell_buffer.sv | 38 +++
 rtl/snake_frame_renderer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake display path.
package snake_pkg;

    localparam int unsigned GRID_W  = 16;
    localparam int unsigned N_CELLS = GRID_W * GRID_W;
    localparam int unsigned ADDR_W  = $clog2(N_CELLS);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FOOD  = 2'b01,
        BODY  = 2'b10,
        HEAD  = 2'b11
    } cell_t;

    typedef logic [N_CELLS-1:0][ADDR_W-1:0] pos_array_t;

endpackage

// File: rtl/snake_cell_buffer.sv
// Double-buffered 16x16 cell map: back buffer written by the renderer,
// front buffer swapped in whole and read combinationally by the display.
module snake_cell_buffer
    import snake_pkg::*;
(
    input  logic              game_clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  cell_t             wr_data,
    input  logic              swap,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_cell
);

    logic [N_CELLS-1:0][1:0] back_buf;
    logic [N_CELLS-1:0][1:0] front_buf;

    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            back_buf  <= '0;
            front_buf <= '0;
        end else begin
            if (clear) begin
                back_buf <= '0;
            end else if (wr_en) begin
                back_buf[wr_addr] <= wr_data;
            end
            if (swap) begin
                front_buf <= back_buf;
            end
        end
    end

    assign rd_cell = front_buf[rd_addr];

endmodule

// File: rtl/snake_frame_renderer.sv
// Snapshots the game state on request and builds a cell map frame:
// clear, place food, walk segments tail-to-head, then swap to the front buffer.
module snake_frame_renderer
    import snake_pkg::*;
(
    input  logic              game_clk,
    input  logic              reset_n,
    input  logic              frame_req,
    input  pos_array_t        positions,
    input  logic [ADDR_W-1:0] length,
    input  logic [ADDR_W-1:0] food_pos,
    input  logic              game_over,
    output logic              busy,
    output logic              frame_done,
    output logic              req_dropped,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_cell,
    output logic              frame_game_over,
    output logic [ADDR_W-1:0] head_pos
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FOOD,
        ST_WALK,
        ST_SWAP
    } state_t;

    state_t            state, state_nxt;
    pos_array_t        pos_snap;
    logic [ADDR_W-1:0] len_snap;
    logic [ADDR_W-1:0] food_snap;
    logic              go_snap;
    logic [ADDR_W-1:0] idx;

    logic              buf_clear;
    logic              buf_wr;
    logic              buf_swap;
    logic [ADDR_W-1:0] wr_addr;
    cell_t             wr_data;

    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        buf_clear = 1'b0;
        buf_wr    = 1'b0;
        buf_swap  = 1'b0;
        wr_addr   = food_snap;
        wr_data   = FOOD;
        case (state)
            ST_IDLE:  if (frame_req) state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                buf_clear = 1'b1;
                state_nxt = ST_FOOD;
            end
            ST_FOOD: begin
                buf_wr    = 1'b1;
                state_nxt = (len_snap == '0) ? ST_SWAP : ST_WALK;
            end
            // Tail first, head last: later writes win, giving HEAD > BODY > FOOD.
            ST_WALK: begin
                buf_wr  = 1'b1;
                wr_addr = pos_snap[idx];
                wr_data = (idx == '0) ? HEAD : BODY;
                if (idx == '0) state_nxt = ST_SWAP;
            end
            ST_SWAP: begin
                buf_swap  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_snap        <= '0;
            len_snap        <= '0;
            food_snap       <= '0;
            go_snap         <= 1'b0;
            idx             <= '0;
            frame_done      <= 1'b0;
            req_dropped     <= 1'b0;
            frame_game_over <= 1'b0;
            head_pos        <= '0;
        end else begin
            frame_done <= (state == ST_SWAP);
            if (frame_req && state == ST_IDLE) begin
                pos_snap  <= positions;
                len_snap  <= length;
                food_snap <= food_pos;
                go_snap   <= game_over;
            end
            if (frame_req && state != ST_IDLE) begin
                req_dropped <= 1'b1;
            end
            if (state == ST_FOOD) begin
                idx <= len_snap - 1'b1;
            end else if (state == ST_WALK && idx != '0) begin
                idx <= idx - 1'b1;
            end
            if (state == ST_SWAP) begin
                frame_game_over <= go_snap;
                head_pos        <= (len_snap == '0) ? '0 : pos_snap[0];
            end
        end
    end

    snake_cell_buffer u_cell_buffer (
        .game_clk (game_clk),
        .reset_n  (reset_n),
        .clear    (buf_clear),
        .wr_en    (buf_wr),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .swap     (buf_swap),
        .rd_addr  (rd_addr),
        .rd_cell  (rd_cell)
    );

endmodule
